// File: rtl/map_fds_conv_gen.sv
`default_nettype none
// ============================================================================
// map_fds_conv_gen : FDS-conversion mapper with 8 KB PRG window at $6000,
//                    PRG-RAM windows, CPU-cycle IRQ and save-state access.
// Revision 1.0
// ============================================================================
module map_fds_conv_gen #(
  parameter int         PRG_BW    = 4,
  parameter int         IRQ_BW    = 12,
  parameter int         HI_RAM_EN = 1,
  parameter logic [7:0] MAP_NUM   = 8'd27
) (
  input  logic              clk,
  input  logic              map_rst,
  input  logic              m2,
  input  logic              cpu_rw,
  input  logic              cpu_ce,
  input  logic [15:0]       cpu_addr,
  input  logic [7:0]        cpu_dat,
  input  logic [13:0]       ppu_addr,
  input  logic              ss_act,
  input  logic              ss_we,
  input  logic [7:0]        ss_addr,
  output logic [7:0]        ss_rdat,
  output logic [PRG_BW+12:0] prg_addr,
  output logic              ram_on,
  output logic              ram_we,
  output logic              rom_ce,
  output logic              ciram_a10,
  output logic              irq
);

  // Counter image wide enough to expose two save-state bytes.
  localparam int C_CW = (IRQ_BW > 16) ? IRQ_BW : 16;

  logic              m2_q, m2_d;
  logic [PRG_BW-1:0] prg_bank_q, prg_bank_d;
  logic              mirror_q, mirror_d;
  logic              ram_dis_q, ram_dis_d;
  logic              irq_en_q, irq_en_d;
  logic              irq_pend_q, irq_pend_d;
  logic [IRQ_BW-1:0] cnt_q, cnt_d;

  logic              strobe;
  logic [7:0]        bank_ext;
  logic [C_CW-1:0]   cnt_ext;
  logic [7:0]        bank_rd;
  logic [C_CW-1:0]   cnt_rd;
  logic              lo_ram, hi_ram, ram_area;
  logic [PRG_BW+1:0] rom_ext;
  logic [PRG_BW-1:0] prg_hi;
  logic [12:0]       prg_lo;
  logic              unused_bits;

  assign strobe = m2_q & ~m2;

  always_comb begin
    m2_d       = m2;
    prg_bank_d = prg_bank_q;
    mirror_d   = mirror_q;
    ram_dis_d  = ram_dis_q;
    irq_en_d   = irq_en_q;
    irq_pend_d = irq_pend_q;
    cnt_d      = cnt_q;
    bank_ext   = 8'(prg_bank_q);
    cnt_ext    = C_CW'(cnt_q);

    if (strobe && !ss_act) begin
      if (irq_en_q) begin
        cnt_d = cnt_q + IRQ_BW'(1);
        if (&cnt_q) irq_pend_d = 1'b1;
      end
      // Register writes come after the tick so an acknowledge wins a wrap.
      if (!cpu_rw) begin
        case (cpu_addr[15:12])
          4'h8: prg_bank_d = cpu_dat[PRG_BW-1:0];
          4'h9: begin
            cnt_d      = '0;
            irq_pend_d = 1'b0;
            irq_en_d   = cpu_dat[7];
          end
          4'hE: mirror_d  = cpu_dat[3];
          4'hF: ram_dis_d = cpu_dat[4];
          default: ;
        endcase
      end
    end

    if (strobe && ss_act && ss_we) begin
      case (ss_addr)
        8'd0: begin
          bank_ext[3:0] = cpu_dat[3:0];
          prg_bank_d    = bank_ext[PRG_BW-1:0];
          ram_dis_d     = cpu_dat[4];
          mirror_d      = cpu_dat[5];
        end
        8'd1: prg_bank_d = cpu_dat[PRG_BW-1:0];
        8'd2: begin
          irq_en_d   = cpu_dat[7];
          irq_pend_d = cpu_dat[6];
        end
        8'd3: begin
          cnt_ext[7:0] = cpu_dat;
          cnt_d        = cnt_ext[IRQ_BW-1:0];
        end
        8'd4: begin
          cnt_ext[15:8] = cpu_dat;
          cnt_d         = cnt_ext[IRQ_BW-1:0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge map_rst) begin
    if (map_rst) begin
      m2_q       <= 1'b0;
      prg_bank_q <= '0;
      mirror_q   <= 1'b0;
      ram_dis_q  <= 1'b0;
      irq_en_q   <= 1'b0;
      irq_pend_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      m2_q       <= m2_d;
      prg_bank_q <= prg_bank_d;
      mirror_q   <= mirror_d;
      ram_dis_q  <= ram_dis_d;
      irq_en_q   <= irq_en_d;
      irq_pend_q <= irq_pend_d;
      cnt_q      <= cnt_d;
    end
  end

  assign irq = irq_pend_q;

  // Address decode.
  assign lo_ram   = (cpu_addr[15:13] == 3'd3);
  assign hi_ram   = (HI_RAM_EN != 0) && (cpu_addr >= 16'hB800) && (cpu_addr < 16'hD800);
  assign ram_area = lo_ram | hi_ram;
  assign ram_on   = ~cpu_rw | (ram_area & ~ram_dis_q);
  assign ram_we   = ~cpu_rw & ram_area & m2;
  assign rom_ce   = (lo_ram | ~cpu_ce) & ~ram_on;

  // Upper 32 KB: all-ones bank bits with A14:A13 in the low two.
  assign rom_ext = {{PRG_BW{1'b1}}, cpu_addr[14:13]};

  always_comb begin
    prg_lo = cpu_addr[12:0];
    if (ram_on && !cpu_ce) prg_lo = cpu_addr[12:0] - 13'h1800;
    if (ram_on)      prg_hi = hi_ram ? PRG_BW'(1) : '0;
    else if (lo_ram) prg_hi = ram_dis_q ? prg_bank_q : '0;
    else             prg_hi = rom_ext[PRG_BW-1:0];
  end

  assign prg_addr  = {prg_hi, prg_lo};
  assign ciram_a10 = mirror_q ? ppu_addr[11] : ppu_addr[10];

  // Save-state readback.
  assign bank_rd = 8'(prg_bank_q);
  assign cnt_rd  = C_CW'(cnt_q);

  always_comb begin
    case (ss_addr)
      8'd0:    ss_rdat = {2'b00, mirror_q, ram_dis_q, bank_rd[3:0]};
      8'd1:    ss_rdat = bank_rd;
      8'd2:    ss_rdat = {irq_en_q, irq_pend_q, 6'b0};
      8'd3:    ss_rdat = cnt_rd[7:0];
      8'd4:    ss_rdat = cnt_rd[15:8];
      8'd127:  ss_rdat = MAP_NUM;
      default: ss_rdat = 8'hFF;
    endcase
  end

  assign unused_bits = ^{ppu_addr, bank_ext, cnt_ext, cnt_rd, rom_ext};

endmodule
`default_nettype wire

// File: doc/map_fds_conv_gen.md
Name: map_fds_conv_gen

Overview:
- Parametrised successor to the single-bank FDS-conversion mapper.
- Provides a switchable 8 KB PRG window at $6000 with configurable bank width, plus a fixed upper 32 KB.
- Provides PRG-RAM mapping at $6000 and, optionally, at $B800–$D7FF, with H/V mirroring.
- Adds a CPU-cycle IRQ counter and full save-state coverage. Sits in the mapper slot and drives the PRG/SRM/CIRAM address paths.

Parameters:
- PRG_BW, 4: width of the PRG bank register, 1..8.
- IRQ_BW, 12: IRQ counter width; IRQ period is 2^IRQ_BW CPU cycles.
- HI_RAM_EN, 1: 1 maps the $B800–$D7FF RAM window; 0 leaves the window unmapped.
- MAP_NUM, 8'd27: value returned at save-state address 127.

Ports:
- clk  in  1  system clock.
- map_rst  in  1  asynchronous active-high reset.
- m2  in  1  CPU M2, already synchronous to clk.
- cpu_rw  in  1  1 = read.
- cpu_ce  in  1  active-low $8000–$FFFF select.
- cpu_addr  in  16  CPU address.
- cpu_dat  in  8  CPU write data.
- ppu_addr  in  14  PPU address.
- ss_act  in  1  save-state mode.
- ss_we  in  1  save-state write.
- ss_addr  in  8  save-state register index.
- ss_rdat  out  8  save-state readback.
- prg_addr  out  PRG_BW+13  PRG/RAM address.
- ram_on  out  1  RAM selected.
- ram_we  out  1  RAM write strobe.
- rom_ce  out  1  ROM select.
- ciram_a10  out  1  nametable select.
- irq  out  1  active-high IRQ request.

Behaviour:
- Clocking:
  - m2_d registers m2 every clk.
  - strobe = m2_d & !m2 (falling M2, one clk wide).
  - All register updates and counter ticks happen only on strobe. No other state changes.
- Reset (async on map_rst):
  - prg_bank=0, mirror=0, ram_dis=0, irq_en=0, irq_pend=0, cnt=0, m2_d=0.
  - Therefore irq=0.
- Register writes (strobe & !cpu_rw & !ss_act):
  - $8xxx: prg_bank <= cpu_dat[PRG_BW-1:0].
  - $9xxx: cnt <= 0, irq_pend <= 0, irq_en <= cpu_dat[7]. This is both acknowledge and enable/disable.
  - $Exxx: mirror <= cpu_dat[3].
  - $Fxxx: ram_dis <= cpu_dat[4].
  - All other addresses: no register effect.
- IRQ counter:
  - On strobe with irq_en & !ss_act: cnt <= cnt+1, modulo 2^IRQ_BW.
  - When cnt is all-ones at that strobe: irq_pend <= 1, and cnt wraps to 0 and keeps counting.
  - irq = irq_pend. It stays high until a $9xxx write or reset.
  - A $9xxx write on the same strobe as the wrap wins: irq_pend=0, cnt=0.
  - Counting stops while irq_en=0; cnt holds.
- Address decode (combinational):
  - lo_ram = cpu_addr[15:13]==3.
  - hi_ram = HI_RAM_EN & cpu_addr in [$B800,$D800).
  - ram_area = lo_ram | hi_ram.
  - ram_on = !cpu_rw | (ram_area & !ram_dis).
  - ram_we = !cpu_rw & ram_area & m2.
  - rom_ce = (lo_ram | !cpu_ce) & !ram_on.
- prg_addr[12:0]:
  - ram_on & cpu_ce=0: cpu_addr-13'h1800.
  - Otherwise: cpu_addr[12:0].
- prg_addr high bits:
  - ram_on: 0 for lo RAM, 1 for hi RAM.
  - lo_ram: ram_dis ? prg_bank : 0.
  - Else: {all-ones, cpu_addr[14:13]}, i.e. the top 32 KB of the PRG space.
- ciram_a10 = mirror ? ppu_addr[11] : ppu_addr[10].
- Save state:
  - While ss_act: normal writes and counting are suspended. ss_we on strobe loads the register selected by ss_addr from cpu_dat.
  - Index 0: {2'b00, mirror, ram_dis, prg_bank[3:0]}.
  - Index 1: prg_bank zero-extended to 8 bits.
  - Index 2: {irq_en, irq_pend, 6'b0}.
  - Index 3: cnt[7:0].
  - Index 4: cnt[IRQ_BW-1:8], zero-extended; reads 0 when IRQ_BW≤8.
  - Index 127: MAP_NUM.
  - Any other index: 8'hFF.
  - Writes to index 1 override index 0's bank bits. If both are written, the last write wins.
  - ss_rdat is combinational.
- Reset mid-operation clears everything immediately, including a pending IRQ. A strobe coincident with reset release is ignored.

Test Plan:
- Reset, then read $E000 → rom_ce=1, prg_addr={all-ones,2'b11,13'h0000}. Read $6000 with ram_dis=0 → ram_on=1, prg_addr=0, irq=0.
- PRG_BW=6: write $8000=$2A, $F000=$10, read $6123 → ram_on=0, prg_addr={6'h2A,13'h0123}. Write $F000=$00 → RAM returns at $6000.
- HI_RAM_EN=1: write $C000=$55 → ram_we pulses with m2, prg_addr={…1,13'h0800}. HI_RAM_EN=0: same write → ram_we=0.
- IRQ_BW=4: write $9000=$80, issue 15 strobes → irq=0. 16th strobe → irq=1, cnt=0. Write $9000=$00 → irq=0 and cnt holds at 0 over 20 further strobes.
- IRQ_BW=4: enable, reach cnt=15, and on the same strobe write $9000=$80 → irq stays 0, cnt=0. IRQ fires again exactly 16 strobes later.
- Save/restore: with prg_bank=5, mirror=1, irq_en=1, cnt=$123 → ss_rdat idx0=$25, idx2=$80, idx3=$23, idx4=$01, idx127=27. Reset, write back indices 0/2/3/4 → identical state; irq fires after $EDD more strobes.
